// File: rtl/ss_multi.sv
// ----------------------------------------------------------------------------
// ss_multi -- bank of N independent tick-timed single-shot pulse generators.
//
// Each channel fires on a rising edge of its trigger level and holds its shot
// output high for a run-time programmable number of timebase ticks. A channel
// can be retriggerable, which restarts the count on a new trigger, or
// non-retriggerable, which ignores triggers while busy. An optional hold-off
// dead time follows every normally expiring shot.
//
// Ports
//   clk      system clock, all state on posedge
//   rst      asynchronous reset, active low
//   tick     timebase strobe, one clk wide; paces all counting
//   t        per-channel trigger level (rising edge fires)
//   retrig   per-channel mode, 1 = retriggerable
//   cancel   per-channel synchronous abort, overrides everything
//   cfg_we   duration register write strobe
//   cfg_ch   channel addressed by cfg_we (values >= N are ignored)
//   cfg_dur  new duration in ticks, 0 disables the channel
//   s        registered shot outputs
//   busy     registered, channel is in a shot or in hold-off
//   done     registered one-clk pulse when a shot expires normally
// ----------------------------------------------------------------------------
module ss_multi #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  parameter  int D    = 10,
  parameter  int HOLD = 0,
  localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [N-1:0]  t,
  input  logic [N-1:0]  retrig,
  input  logic [N-1:0]  cancel,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_dur,
  output logic [N-1:0]  s,
  output logic [N-1:0]  busy,
  output logic [N-1:0]  done
);

  localparam logic [1:0]   ST_IDLE   = 2'd0;
  localparam logic [1:0]   ST_ACTIVE = 2'd1;
  localparam logic [1:0]   ST_HOLD   = 2'd2;

  localparam logic [W-1:0] CTR_ZERO  = W'(0);
  localparam logic [W-1:0] CTR_ONE   = W'(1);
  localparam logic [W-1:0] DUR_RST   = W'(D);
  localparam logic [W-1:0] HOLD_W    = W'(HOLD);

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [1:0]   r_state;
    logic [W-1:0] r_ctr;
    logic [W-1:0] r_dur;
    logic         r_pend;
    logic         r_t_prev;
    logic         r_s;
    logic         r_busy;
    logic         r_done;

    logic [1:0]   w_state_nx;
    logic [W-1:0] w_ctr_nx;
    logic         w_pend_nx;
    logic         w_done_nx;
    logic         w_edge;
    logic         w_trig;
    logic         w_dur_ok;
    logic         w_cfg_hit;

    // t_prev resets to 1 so a level already high at reset release is no edge.
    assign w_edge    = t[g] & ~r_t_prev;
    // A pending edge and a fresh edge in the tick clk are one trigger.
    assign w_trig    = r_pend | w_edge;
    assign w_dur_ok  = (r_dur != CTR_ZERO);
    assign w_cfg_hit = cfg_we & (cfg_ch == CW'(g));

    // Next-state logic: cancel beats everything, otherwise only ticks advance.
    always_comb begin
      w_state_nx = r_state;
      w_ctr_nx   = r_ctr;
      w_pend_nx  = r_pend | w_edge;
      w_done_nx  = 1'b0;
      if (cancel[g]) begin
        w_state_nx = ST_IDLE;
        w_ctr_nx   = CTR_ZERO;
        w_pend_nx  = 1'b0;
      end else if (tick) begin
        // Every trigger seen at a tick is consumed, used or not.
        w_pend_nx = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_trig && w_dur_ok) begin
              w_state_nx = ST_ACTIVE;
              w_ctr_nx   = r_dur;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end
          ST_ACTIVE: begin
            // Reload wins over expiry; a disabled channel cannot reload.
            if (retrig[g] && w_trig && w_dur_ok) begin
              w_ctr_nx = r_dur;
            end else if (r_ctr == CTR_ONE) begin
              w_done_nx = 1'b1;
              if (HOLD != 0) begin
                w_state_nx = ST_HOLD;
                w_ctr_nx   = HOLD_W;
              end else begin
                w_state_nx = ST_IDLE;
                w_ctr_nx   = CTR_ZERO;
              end
            end else begin
              w_ctr_nx = r_ctr - CTR_ONE;
            end
          end
          ST_HOLD: begin
            if (r_ctr == CTR_ONE) begin
              w_state_nx = ST_IDLE;
              w_ctr_nx   = CTR_ZERO;
            end else begin
              w_ctr_nx = r_ctr - CTR_ONE;
            end
          end
          default: begin
            w_state_nx = ST_IDLE;
            w_ctr_nx   = CTR_ZERO;
          end
        endcase
      end else begin
        w_state_nx = r_state;
      end
    end

    // Channel state, duration register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state  <= ST_IDLE;
        r_ctr    <= CTR_ZERO;
        r_dur    <= DUR_RST;
        r_pend   <= 1'b0;
        r_t_prev <= 1'b1;
        r_s      <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        r_state  <= w_state_nx;
        r_ctr    <= w_ctr_nx;
        r_pend   <= w_pend_nx;
        r_t_prev <= t[g];
        r_s      <= (w_state_nx == ST_ACTIVE);
        r_busy   <= (w_state_nx != ST_IDLE);
        r_done   <= w_done_nx;
        // The write lands at this edge, so a load in the same clk saw the old value.
        if (w_cfg_hit) begin
          r_dur <= cfg_dur;
        end else begin
          r_dur <= r_dur;
        end
      end
    end

    assign s[g]    = r_s;
    assign busy[g] = r_busy;
    assign done[g] = r_done;
  end

endmodule

// File: tb/tb_ss_multi.sv
// ----------------------------------------------------------------------------
// tb_ss_multi -- drives two ss_multi instances (hold-off 0 and hold-off 2,
// duration reset value 3) with the same stimulus and compares every output
// every clk against a remaining-time reference model, plus directed pulse
// length / done count checks for the main scenarios.
// ----------------------------------------------------------------------------
module tb_ss_multi;

  localparam int NCH = 4;
  localparam int DV  = 3;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tick    = 1'b0;
  logic [3:0] t       = 4'h0;
  logic [3:0] retrig  = 4'h0;
  logic [3:0] cancel  = 4'h0;
  logic       cfg_we  = 1'b0;
  logic [1:0] cfg_ch  = 2'd0;
  logic [7:0] cfg_dur = 8'd0;

  logic [3:0] s0, busy0, done0;
  logic [3:0] s1, busy1, done1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining shot ticks, remaining hold-off ticks, etc.
  int m_shot [2][NCH];
  int m_hold [2][NCH];
  int m_dur  [2][NCH];
  bit m_pend [2][NCH];
  bit m_prev [2][NCH];
  bit m_done [2][NCH];
  int holdv  [2] = '{0, 2};

  always #5 clk = ~clk;

  ss_multi #(.N(4), .W(8), .D(3), .HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .t(t), .retrig(retrig), .cancel(cancel),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_dur(cfg_dur),
    .s(s0), .busy(busy0), .done(done0)
  );

  ss_multi #(.N(4), .W(8), .D(3), .HOLD(2)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .t(t), .retrig(retrig), .cancel(cancel),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_dur(cfg_dur),
    .s(s1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCH; i++) begin
        m_shot[d][i] = 0;
        m_hold[d][i] = 0;
        m_dur[d][i]  = DV;
        m_pend[d][i] = 1'b0;
        m_prev[d][i] = 1'b1;
        m_done[d][i] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCH; i++) begin
        bit e;
        bit tr;
        e = t[i] && !m_prev[d][i];
        m_prev[d][i] = t[i];
        m_done[d][i] = 1'b0;
        if (cancel[i]) begin
          m_shot[d][i] = 0;
          m_hold[d][i] = 0;
          m_pend[d][i] = 1'b0;
        end else if (tick) begin
          tr = m_pend[d][i] || e;
          m_pend[d][i] = 1'b0;
          if (m_shot[d][i] > 0) begin
            if (retrig[i] && tr && m_dur[d][i] != 0) begin
              m_shot[d][i] = m_dur[d][i];
            end else if (m_shot[d][i] == 1) begin
              m_shot[d][i] = 0;
              m_done[d][i] = 1'b1;
              m_hold[d][i] = holdv[d];
            end else begin
              m_shot[d][i]--;
            end
          end else if (m_hold[d][i] > 0) begin
            m_hold[d][i]--;
          end else if (tr && m_dur[d][i] != 0) begin
            m_shot[d][i] = m_dur[d][i];
          end
        end else begin
          m_pend[d][i] = m_pend[d][i] || e;
        end
      end
      if (cfg_we) m_dur[d][int'(cfg_ch)] = int'(cfg_dur);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      logic [3:0] es, eb, ed;
      for (int i = 0; i < NCH; i++) begin
        es[i] = (m_shot[d][i] > 0);
        eb[i] = (m_shot[d][i] > 0) || (m_hold[d][i] > 0);
        ed[i] = m_done[d][i];
      end
      if (d == 0) begin
        chk("s_h0", 32'(s0), 32'(es));
        chk("busy_h0", 32'(busy0), 32'(eb));
        chk("done_h0", 32'(done0), 32'(ed));
      end else begin
        chk("s_h2", 32'(s1), 32'(es));
        chk("busy_h2", 32'(busy1), 32'(eb));
        chk("done_h2", 32'(done1), 32'(ed));
      end
    end
  endtask

  // One clk: model follows the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    tick   = 1'b0;
    cancel = 4'h0;
    cfg_we = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    t = 4'h0;
    for (int k = 0; k < n; k++) begin
      tick = ((k % 4) == 0);
      cyc();
    end
  endtask

  // Async reset applied mid-cycle; outputs must drop before any clk edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_s_h0", 32'(s0), 32'd0);
    chk("rst_busy_h0", 32'(busy0), 32'd0);
    chk("rst_done_h0", 32'(done0), 32'd0);
    chk("rst_s_h2", 32'(s1), 32'd0);
    chk("rst_busy_h2", 32'(busy1), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int cnt_s;
    int cnt_d;
    model_reset();
    #1;
    rst = 1'b0;
    #2;
    chk("init_s", 32'({s1, s0}), 32'd0);
    chk("init_busy", 32'({busy1, busy0}), 32'd0);
    chk("init_done", 32'({done1, done0}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_ticks(8);

    // Basic shot on ch0, duration 3, tick every 4 clk.
    cnt_s = 0; cnt_d = 0;
    for (int k = 0; k < 24; k++) begin
      tick = ((k % 4) == 0);
      if (k == 0) t[0] = 1'b1;
      cyc();
      cnt_s += int'(s0[0]);
      cnt_d += int'(done0[0]);
    end
    chk("t1_s_len", 32'(cnt_s), 32'd12);
    chk("t1_done_cnt", 32'(cnt_d), 32'd1);
    idle_ticks(16);

    // Retriggerable ch1 with duration 5, second edge at tick 3.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_dur = 8'd5;
    cyc();
    for (int pass = 0; pass < 2; pass++) begin
      retrig = (pass == 0) ? 4'b0010 : 4'b0000;
      t[1] = 1'b0;
      repeat (4) cyc();
      cnt_s = 0; cnt_d = 0;
      for (int k = 0; k < 48; k++) begin
        tick = ((k % 4) == 0);
        if (k == 0 || k == 12) t[1] = 1'b1;
        if (k == 4) t[1] = 1'b0;
        cyc();
        cnt_s += int'(s0[1]);
        cnt_d += int'(done0[1]);
      end
      chk("t2_s_len", 32'(cnt_s), (pass == 0) ? 32'd32 : 32'd20);
      chk("t2_done_cnt", 32'(cnt_d), 32'd1);
    end
    retrig = 4'h0;
    idle_ticks(16);

    // Hold-off on ch2: edge in hold-off ignored, later edge fires.
    cnt_s = 0; cnt_d = 0;
    for (int k = 0; k < 40; k++) begin
      tick = ((k % 4) == 0);
      if (k == 0 || k == 16 || k == 24) t[2] = 1'b1;
      if (k == 4 || k == 20) t[2] = 1'b0;
      cyc();
      cnt_s += int'(s1[2]);
      cnt_d += int'(done1[2]);
    end
    chk("t3_s_len_h2", 32'(cnt_s), 32'd24);
    chk("t3_done_h2", 32'(cnt_d), 32'd2);
    idle_ticks(16);

    // Duration rewrite mid-shot: running shot keeps 3, next shot uses 7.
    cnt_s = 0;
    for (int k = 0; k < 64; k++) begin
      tick = ((k % 4) == 0);
      if (k == 0 || k == 28) t[2] = 1'b1;
      if (k == 4) t[2] = 1'b0;
      if (k == 6) begin cfg_we = 1'b1; cfg_ch = 2'd2; cfg_dur = 8'd7; end
      cyc();
      cnt_s += int'(s0[2]) + int'(s1[2]);
    end
    chk("t4_s_len", 32'(cnt_s), 32'd80);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_dur = 8'd0;
    idle_ticks(8);
    cnt_s = 0;
    for (int k = 0; k < 20; k++) begin
      tick = ((k % 4) == 0);
      t[2] = ((k % 8) < 4);
      cyc();
      cnt_s += int'(s0[2]) + int'(s1[2]);
    end
    chk("t4_disabled", 32'(cnt_s), 32'd0);
    idle_ticks(16);

    // Cancel ch3 mid-shot: output drops next clk, no done.
    cnt_d = 0;
    for (int k = 0; k < 24; k++) begin
      tick = ((k % 4) == 0);
      if (k == 0) t[3] = 1'b1;
      if (k == 5) cancel = 4'b1000;
      cyc();
      if (k == 5) chk("t5_cancel_s", 32'({s1[3], s0[3]}), 32'd0);
      cnt_d += int'(done0[3]) + int'(done1[3]);
    end
    chk("t5_no_done", 32'(cnt_d), 32'd0);
    idle_ticks(16);

    // Reset mid-shot with triggers held high through release.
    tick = 1'b1; t = 4'hf;
    cyc();
    repeat (5) cyc();
    do_reset();
    cnt_s = 0;
    for (int k = 0; k < 16; k++) begin
      tick = ((k % 4) == 0);
      cyc();
      cnt_s += int'(s0 != 4'h0) + int'(s1 != 4'h0);
    end
    chk("t5_no_fire", 32'(cnt_s), 32'd0);
    idle_ticks(16);

    // Edge without tick stays pending and starts at the next tick.
    for (int k = 0; k < 6; k++) begin
      tick = (k == 4);
      if (k == 1) t[0] = 1'b1;
      cyc();
      if (k == 3) chk("t6_pending", 32'(s0[0]), 32'd0);
      if (k == 4) chk("t6_start", 32'(s0[0]), 32'd1);
    end
    idle_ticks(16);

    // Randomized traffic, every clk checked against the model.
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      t = t ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 15) == 0) retrig = 4'($urandom);
      if ($urandom_range(0, 31) == 0) cancel = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        cfg_we  = 1'b1;
        cfg_ch  = 2'($urandom);
        cfg_dur = 8'($urandom_range(0, 9));
      end
      cyc();
      if (i == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
